// File: rtl/slice_scan_pkg.sv
// Shared types, sizes and the zero-filled part-select helper for the slice scanner.
package slice_scan_pkg;

  localparam int DATA_W  = 15;
  localparam int IDX_W   = 4;
  localparam int SLICE_W = 2;
  localparam int RST_MAX = 3;

  // Restart counter only needs to reach RST_MAX.
  localparam int RCNT_W = $clog2(RST_MAX + 1);

  // Wide enough that any IDX_W+1-bit shift still leaves SLICE_W zero-filled bits.
  localparam int EXT_W = (1 << (IDX_W + 1)) + SLICE_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  // word[idx +: SLICE_W] with every bit at or above DATA_W reading as 0.
  function automatic logic [SLICE_W-1:0] slice_at(input logic [DATA_W-1:0] word,
                                                  input logic [IDX_W:0]    idx);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(word) >> idx;
    return ext[SLICE_W-1:0];
  endfunction

endpackage

// File: rtl/slice_scan_change_det.sv
// Holds the word snapshot, flags a live-word change and counts consecutive restarts.
module slice_scan_change_det
  import slice_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              capture,   // new scan accepted: snapshot and clear count
  input  logic              restart,   // scan restarted: re-snapshot and count it
  output logic [DATA_W-1:0] snapshot,
  output logic              changed,
  output logic              at_max
);

  logic [DATA_W-1:0] snap_q;
  logic [RCNT_W-1:0] rcnt_q;

  assign snapshot = snap_q;
  assign changed  = (data != snap_q);
  assign at_max   = (rcnt_q == RCNT_W'(RST_MAX));

  // Snapshot and restart counter update on scan start or restart only.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      rcnt_q <= '0;
    end else if (capture) begin
      snap_q <= data;
      rcnt_q <= '0;
    end else if (restart) begin
      snap_q <= data;
      rcnt_q <= rcnt_q + RCNT_W'(1);
    end
  end

endmodule

// File: rtl/slice_scan_ctrl.sv
// Scan FSM: steps an index over the snapshot word and streams slices on valid/ready,
// restarting on a word change and aborting after too many consecutive restarts.
module slice_scan_ctrl
  import slice_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data,
  input  logic               start,
  input  logic [IDX_W-1:0]   base_idx,
  input  logic [IDX_W-1:0]   count,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [SLICE_W-1:0] out_slice,
  output logic               out_last,
  output logic               aborted
);

  state_t             state_q, state_d;
  logic [IDX_W:0]     idx_q, idx_d;      // one bit wider so the index never wraps
  logic [IDX_W:0]     base_q, base_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rem_q, rem_d;
  logic               valid_q, valid_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic               abort_q, abort_d;

  logic               capture, restart;
  logic               changed, at_max;
  logic [DATA_W-1:0]  snapshot;
  logic [IDX_W-1:0]   count_eff;

  slice_scan_change_det u_change_det (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .capture  (capture),
    .restart  (restart),
    .snapshot (snapshot),
    .changed  (changed),
    .at_max   (at_max)
  );

  assign count_eff = (count == '0) ? IDX_W'(1) : count;

  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_idx   = idx_q[IDX_W-1:0];
  assign out_slice = slice_q;
  assign out_last  = valid_q && (rem_q == IDX_W'(1));
  assign aborted   = abort_q;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      slice_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      slice_q <= slice_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic; a word change while busy overrides any handshake this cycle.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    slice_d = slice_q;
    abort_d = 1'b0;
    capture = 1'b0;
    restart = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          base_d  = {1'b0, base_idx};
          idx_d   = {1'b0, base_idx};
          cnt_d   = count_eff;
          rem_d   = count_eff;
          state_d = SCAN;
        end
      end
      SCAN: begin
        slice_d = slice_at(snapshot, idx_q);
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - IDX_W'(1);
          if (rem_q == IDX_W'(1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + (IDX_W + 1)'(1);
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy && changed) begin
      valid_d = 1'b0;
      if (at_max) begin
        abort_d = 1'b1;
        state_d = IDLE;
      end else begin
        restart = 1'b1;
        idx_d   = base_q;
        rem_d   = cnt_q;
        state_d = SCAN;
      end
    end
  end

endmodule

// File: tb/tb_slice_scan_ctrl.sv
// Self-checking bench for slice_scan_ctrl: hand-derived vector table, directed
// corner sequences and randomized scans against a list-of-slices reference model.
module tb_slice_scan_ctrl;
  import slice_scan_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  data;
  logic               start;
  logic [IDX_W-1:0]   base_idx;
  logic [IDX_W-1:0]   count;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic [SLICE_W-1:0] out_slice;
  logic               out_last;
  logic               aborted;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] got_idx[$];
  logic [1:0] got_slice[$];
  logic       got_last[$];

  typedef struct {
    logic [14:0] d;
    logic [3:0]  b;
    logic [3:0]  c;
    int          n;
    logic [15:0] exp;   // slice k expected at exp[2k +: 2]
  } vec_t;

  vec_t tbl[5];

  slice_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .start     (start),
    .base_idx  (base_idx),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_slice (out_slice),
    .out_last  (out_last),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: bit j of the slice is word bit p+j, or 0 past the top of the word.
  function automatic logic [1:0] model_slice(input logic [14:0] d, input int p);
    logic [31:0] w;
    logic b0, b1;
    w  = 32'(d);
    b0 = (p < 15)     && (((w >> p) & 32'd1) != 0);
    b1 = (p + 1 < 15) && (((w >> (p + 1)) & 32'd1) != 0);
    return {b1, b0};
  endfunction

  task automatic do_start(input logic [14:0] d, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    data     = d;
    base_idx = b;
    count    = c;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Drives ready at random, records every handshake, checks stall stability,
  // and returns once the scan is over or the cycle budget runs out.
  task automatic collect(input int pct, input int budget);
    bit          pv;
    bit          done;
    logic [3:0]  pidx;
    logic [1:0]  pslice;
    pv   = 0;
    done = 0;
    pidx = '0;
    pslice = '0;
    got_idx.delete();
    got_slice.delete();
    got_last.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (pv) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_idx",   32'(out_idx),   32'(pidx));
        check("stall_slice", 32'(out_slice), 32'(pslice));
      end
      if (!busy && !out_valid) begin
        done = 1;
        break;
      end
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        got_idx.push_back(out_idx);
        got_slice.push_back(out_slice);
        got_last.push_back(out_last);
      end
      pv     = out_valid && !out_ready;
      pidx   = out_idx;
      pslice = out_slice;
    end
    if (!done) check("scan_timeout", 32'd0, 32'd1);
  endtask

  // Compares the collected handshakes with the scan the model predicts.
  task automatic compare_model(input logic [14:0] d, input logic [3:0] b, input logic [3:0] c);
    int n;
    n = (c == 0) ? 1 : int'(c);
    check("rnd_count", 32'(got_idx.size()), 32'(n));
    for (int k = 0; k < n && k < got_idx.size(); k++) begin
      check("rnd_idx",   32'(got_idx[k]),   32'((int'(b) + k) % 16));
      check("rnd_slice", 32'(got_slice[k]), 32'(model_slice(d, int'(b) + k)));
      check("rnd_last",  32'(got_last[k]),  32'(k == n - 1));
    end
  endtask

  initial begin
    bit          flipped, flip_chk, bad_valid;
    int          n_ab, ab_cyc;
    logic [14:0] rd;
    logic [3:0]  rb, rc;

    // data, base, count, slices, hand-derived slice list
    tbl[0] = '{15'h5A3C, 4'd1,  4'd4, 4, 16'h00FE};  // 10,11,11,11
    tbl[1] = '{15'h7FFF, 4'd14, 4'd2, 2, 16'h0001};  // 01,00 (no wrap)
    tbl[2] = '{15'h0004, 4'd2,  4'd0, 1, 16'h0001};  // count 0 -> one slice
    tbl[3] = '{15'h4000, 4'd13, 4'd3, 3, 16'h0006};  // 10,01,00
    tbl[4] = '{15'h1234, 4'd0,  4'd3, 3, 16'h0018};  // 00,10,01

    rst = 1'b1; data = '0; start = 1'b0; base_idx = '0; count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_idx",     32'(out_idx),   32'd0);
    check("rst_slice",   32'(out_slice), 32'd0);
    check("rst_last",    32'(out_last),  32'd0);
    check("rst_aborted", 32'(aborted),   32'd0);
    rst = 1'b0;

    // Table: full scans with ready always high.
    foreach (tbl[i]) begin
      do_start(tbl[i].d, tbl[i].b, tbl[i].c);
      collect(100, 200);
      check("tbl_count", 32'(got_idx.size()), 32'(tbl[i].n));
      for (int k = 0; k < tbl[i].n && k < got_idx.size(); k++) begin
        check("tbl_idx",   32'(got_idx[k]),   32'(tbl[i].b + 4'(k)));
        check("tbl_slice", 32'(got_slice[k]), 32'(tbl[i].exp[2*k +: 2]));
        check("tbl_last",  32'(got_last[k]),  32'(k == tbl[i].n - 1));
      end
      check("tbl_busy_end", 32'(busy), 32'd0);
    end

    // Latency and stall: first slice two cycles after start, held while ready=0.
    out_ready = 1'b0;
    do_start(15'h5A3C, 4'd1, 4'd4);
    check("lat_scan_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_first_valid", 32'(out_valid), 32'd1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_idx",   32'(out_idx),   32'd1);
      check("hold_slice", 32'(out_slice), 32'h2);
    end
    collect(100, 200);
    compare_model(15'h5A3C, 4'd1, 4'd4);

    // Word change at idx2 restarts the scan from base with the new word.
    out_ready = 1'b0;
    flipped = 0; flip_chk = 0;
    do_start(15'h1234, 4'd0, 4'd5);
    got_idx.delete(); got_slice.delete(); got_last.delete();
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (flip_chk) begin
        check("restart_drop", 32'(out_valid), 32'd0);
        flip_chk = 0;
      end
      if (!busy) break;
      if (out_valid && out_idx == 4'd2 && !flipped) begin
        data      = 15'h123C;
        out_ready = 1'b0;
        flipped   = 1;
        flip_chk  = 1;
      end else begin
        out_ready = 1'b1;
        if (out_valid && flipped) begin
          got_idx.push_back(out_idx);
          got_slice.push_back(out_slice);
          got_last.push_back(out_last);
        end
      end
    end
    compare_model(15'h123C, 4'd0, 4'd5);

    // Four changes in one scan: three restarts, then a single abort pulse.
    out_ready = 1'b0;
    n_ab = 0; ab_cyc = 0; bad_valid = 0;
    do_start(15'h0000, 4'd0, 4'd8);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (aborted) begin
        n_ab++;
        if (ab_cyc == 0) ab_cyc = cyc;
      end
      if (n_ab > 0 && out_valid) bad_valid = 1;
      if (cyc % 3 == 0 && cyc <= 12) data = data ^ 15'h0001;
    end
    check("abort_pulses",      32'(n_ab),      32'd1);
    check("abort_cycle",       32'(ab_cyc),    32'd13);
    check("abort_idle",        32'(busy),      32'd0);
    check("abort_no_valid",    32'(bad_valid), 32'd0);

    // Async reset mid-HOLD clears outputs at once; the next scan is normal.
    do_start(15'h5A3C, 4'd2, 4'd3);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_idx",   32'(out_idx),   32'd0);
    check("mid_rst_slice", 32'(out_slice), 32'd0);
    check("mid_rst_last",  32'(out_last),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // A start pulse while busy changes neither index nor count.
    do_start(15'h2D6B, 4'd3, 4'd2);
    @(negedge clk);
    start = 1'b1; base_idx = 4'd9; count = 4'd7;
    @(negedge clk);
    start = 1'b0;
    collect(100, 200);
    compare_model(15'h2D6B, 4'd3, 4'd2);

    // Randomized scans with random back-pressure.
    for (int j = 0; j < 20; j++) begin
      rd = 15'($urandom);
      rb = 4'($urandom_range(15));
      rc = 4'($urandom_range(15));
      do_start(rd, rb, rc);
      collect(70, 600);
      compare_model(rd, rb, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
